// File: rtl/umult_feeder_pkg.sv
// rtl/umult_feeder_pkg.sv - shared constants and FSM state type for the multiplier feeder
package umult_feeder_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 2 * DEF_WIDTH + 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/umult_op_fifo.sv
// rtl/umult_op_fifo.sv - operand-pair FIFO with registered full/empty and no bypass
module umult_op_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Flags come only from the registered count, so a pop never unblocks a push in the same cycle
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; written only when a push is actually accepted
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset wins over any push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/umult_feeder.sv
// rtl/umult_feeder.sv - queues operand pairs and sequences them through a multi-cycle multiplier
module umult_feeder
  import umult_feeder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = 2 * WIDTH + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               m_start,
  output logic [WIDTH-1:0]   m_a,
  output logic [WIDTH-1:0]   m_b,
  input  logic               m_valid,
  input  logic               m_busy,
  input  logic [2*WIDTH-1:0] m_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic               err
);

  localparam int              CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

  state_t             state;
  state_t             state_nx;
  logic [2*WIDTH-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               result_ok;

  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign result_ok = m_valid && !m_busy;

  umult_op_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, start pulse, FIFO pop and operand drive; operands come straight from the head while issuing
  always_comb begin
    state_nx = state;
    m_start  = 1'b0;
    pop      = 1'b0;
    m_a      = a_q;
    m_b      = b_q;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        m_start  = 1'b1;
        pop      = 1'b1;
        m_a      = head[2*WIDTH-1:WIDTH];
        m_b      = head[WIDTH-1:0];
        state_nx = WAIT;
      end
      WAIT: begin
        if (result_ok) begin
          state_nx = HOLD;
        end else if (cnt == TO_VAL) begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issued-operand hold, wait counter, result capture and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          a_q <= head[2*WIDTH-1:WIDTH];
          b_q <= head[WIDTH-1:0];
          cnt <= '0;
        end
        WAIT: begin
          if (result_ok) begin
            out_z     <= m_z;
            out_valid <= 1'b1;
          end else if (cnt == TO_VAL) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/umult_feeder.md
UMULT_FEEDER -- requirements
Module: umult_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width; it SHALL match the multiplier WIDTH.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the operand FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter TIMEOUT, default 2*WIDTH+6, giving the maximum cycles to wait for the multiplier result.
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  FIFO can accept a pair.
REQ-008 in_a, in_b  in  WIDTH  operands.
REQ-009 m_start  out  1  start pulse to the multiplier.
REQ-010 m_a, m_b  out  WIDTH  operands to the multiplier.
REQ-011 m_valid, m_busy  in  1  multiplier status.
REQ-012 m_z  in  2*WIDTH  multiplier product.
REQ-013 out_valid  out  1  result held.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_z  out  2*WIDTH  product.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 The block SHALL push {in_a,in_b} into the FIFO on any cycle where in_valid && in_ready.
REQ-018 in_ready SHALL equal !full, registered-state based; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-019 A pair pushed into an empty FIFO SHALL become visible at the head on the following cycle, with no bypass.
REQ-020 The block SHALL use the FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-021 IDLE -> ISSUE SHALL occur when the FIFO is non-empty.
REQ-022 In ISSUE the block SHALL assert m_start for exactly one cycle with m_a/m_b driven from the FIFO head, pop the head, and go to WAIT.
REQ-023 m_a/m_b SHALL hold the issued operands until the next ISSUE; m_start SHALL be 0 in all other states.
REQ-024 In WAIT a cycle counter SHALL start at 0 and increment each cycle.
REQ-025 In WAIT, m_valid && !m_busy SHALL capture m_z into out_z, set out_valid, and go to HOLD.
REQ-026 In WAIT, a counter value of TIMEOUT without result SHALL set err, leave out_valid at 0, drop the pair, and go to IDLE.
REQ-027 In HOLD, out_valid and out_z SHALL stay stable until out_ready; on out_valid && out_ready the block SHALL clear out_valid and go to IDLE.
REQ-028 Issue-to-issue spacing SHALL be at least one IDLE cycle; FIFO pushes SHALL continue in every state.
REQ-029 Products SHALL be delivered in push order, with exact 2*WIDTH-bit width and no truncation.
REQ-030 err SHALL remain 1 until rst.

Reset
REQ-031 On rst the block SHALL set state=IDLE, empty the FIFO (in_ready=1), m_start=0, m_a=m_b=0, out_valid=0, out_z=0, err=0 and counter=0.
REQ-032 rst mid-WAIT SHALL discard the in-flight product; the multiplier is not reset, and the next m_start SHALL restart it.
REQ-033 rst SHALL take priority over push, pop and handshakes in the same cycle.

Structure
REQ-034 A shared package umult_feeder_pkg SHALL hold the FSM state type and the default WIDTH, DEPTH and TIMEOUT constants.
REQ-035 The FIFO SHALL be the sub-module umult_op_fifo, parameterised by data width 2*WIDTH and DEPTH, exposing full, empty, push, pop and head.

Verification
REQ-036 Push 13,11 with out_ready=1 -> one m_start pulse with m_a=13, m_b=11; out_valid=1 with out_z=143 within TIMEOUT cycles.
REQ-037 Push (15,15), (0,9), (1,1) back-to-back -> out_z sequence 225, 0, 1 in order, with one m_start per pair.
REQ-038 Push 5 pairs without popping, DEPTH=4, out_ready=0 -> in_ready=0 after 4 (or 5 if one is already issued) accepted; no pair lost; results delivered in order once out_ready=1.
REQ-039 Hold out_ready=0 for 20 cycles after a result -> out_z stable, out_valid=1, no further m_start until handshake.
REQ-040 Model multiplier never asserting m_valid -> err=1 exactly TIMEOUT cycles into WAIT, FSM returns to IDLE, next pair issues.
REQ-041 Assert rst during WAIT -> next cycle all outputs equal reset values, and a following pushed pair completes correctly.
